// File: rtl/chacha_qr_engine.sv
// ChaCha quarter-round sequencer: walks column/diagonal rounds over an external
// 16-word state store, one ARX step per cycle, writing each quarter-round back.
module chacha_qr_engine #(
   parameter int DOUBLE_ROUNDS = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic [31:0] c_in,
   input  logic [31:0] d_in,
   output logic [31:0] a_out,
   output logic [31:0] b_out,
   output logic [31:0] c_out,
   output logic [31:0] d_out,
   output logic        wr_qr,
   output logic        round_sel,
   output logic [1:0]  qr_sel,
   output logic        busy,
   output logic        done
);

   localparam int DR_W = (DOUBLE_ROUNDS > 1) ? $clog2(DOUBLE_ROUNDS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STEP1,
      STEP2,
      STEP3,
      STEP4,
      WRITE,
      DONE
   } state_t;

   state_t            state;
   logic [31:0]       a, b, c, d;
   logic [DR_W-1:0]   dr_cnt;
   logic              dr_last;

   logic [63:0]       ad_r16, cb_r12, ad_r8, cb_r7;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int r);
      return (v << r) | (v >> (32 - r));
   endfunction

   // One add-xor-rotate half step: returns {x + y, (z ^ (x + y)) rotl r}.
   function automatic logic [63:0] arx(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input int r);
      logic [31:0] s;
      s = x + y;
      return {s, rotl(z ^ s, r)};
   endfunction

   always_comb begin
      ad_r16 = arx(a, b, d, 16);
      cb_r12 = arx(c, d, b, 12);
      ad_r8  = arx(a, b, d, 8);
      cb_r7  = arx(c, d, b, 7);
   end

   assign dr_last = (dr_cnt == DR_W'(DOUBLE_ROUNDS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         a         <= '0;
         b         <= '0;
         c         <= '0;
         d         <= '0;
         a_out     <= '0;
         b_out     <= '0;
         c_out     <= '0;
         d_out     <= '0;
         wr_qr     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         qr_sel    <= 2'd0;
         round_sel <= 1'b0;
         dr_cnt    <= '0;
      end else begin
         wr_qr <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               a     <= a_in;
               b     <= b_in;
               c     <= c_in;
               d     <= d_in;
               state <= STEP1;
            end
            STEP1: begin
               {a, d} <= ad_r16;
               state  <= STEP2;
            end
            STEP2: begin
               {c, b} <= cb_r12;
               state  <= STEP3;
            end
            STEP3: begin
               {a, d} <= ad_r8;
               state  <= STEP4;
            end
            // Final step also loads the write-back registers so they are valid in WRITE.
            STEP4: begin
               {c, b} <= cb_r7;
               a_out  <= a;
               d_out  <= d;
               {c_out, b_out} <= cb_r7;
               wr_qr  <= 1'b1;
               state  <= WRITE;
            end
            WRITE: begin
               qr_sel <= qr_sel + 2'd1;
               state  <= LOAD;
               if (qr_sel == 2'd3) begin
                  round_sel <= ~round_sel;
                  if (round_sel) begin
                     if (dr_last) begin
                        dr_cnt <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                     end else begin
                        dr_cnt <= dr_cnt + 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
